// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the integer register scoreboard.
//   SB_NREG   : number of architectural integer registers tracked
//   SB_CNT_W  : width of each per-register pending-write counter
//   reg_idx_t : 5-bit architectural register index
package reg_scoreboard_pkg;
    localparam int SB_NREG  = 32;
    localparam int SB_CNT_W = 2;

    typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One scoreboard slot: pending-write counter for a single register.
// Ports:
//   clk, reset : clock, async active-high reset
//   clear      : synchronous clear (flush), wins over inc/dec
//   inc, dec   : issue of a write / retirement of a write this cycle
//   cnt        : registered pending-write count
//   busy       : cnt != 0
//   underflow  : dec requested while cnt == 0 (combinational pulse)
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             underflow
);
    // Simultaneous inc and dec cancel; dec at zero is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy      = (cnt != '0);
    assign underflow = dec && (cnt == '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per integer register and
// stalls issue on RAW hazards or when a destination counter is saturated.
// Optional macro: SCOREBOARD_BYPASS_EN -- a source whose only pending write
// retires in the same cycle is treated as ready (saves one stall cycle).
// Ports:
//   clk, reset                 : clock, async active-high reset
//   issue_valid / issue_ready  : decode handshake (ready is combinational)
//   issue_rs1/rs2/rd           : register indices
//   issue_use_rs1/rs2          : operand actually read
//   issue_is_write             : instruction writes rd
//   wb_valid, wb_rd            : writeback retires one write to wb_rd
//   flush                      : discard all pending writes
//   busy_mask                  : per-register pending-write flag
//   wb_underflow               : sticky, writeback with no pending write
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  reg_idx_t        issue_rs1,
    input  reg_idx_t        issue_rs2,
    input  reg_idx_t        issue_rd,
    input  logic            issue_use_rs1,
    input  logic            issue_use_rs2,
    input  logic            issue_is_write,
    input  logic            wb_valid,
    input  reg_idx_t        wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy_mask,
    output logic            wb_underflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            uf_hit;
    logic [NREG-1:0]            inc_vec;
    logic [NREG-1:0]            dec_vec;

    logic rs1_bypass, rs2_bypass;
    logic raw1, raw2, waw;
    logic issue_fire, wb_fire;

`ifdef SCOREBOARD_BYPASS_EN
    assign rs1_bypass = wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == CNT_ONE);
    assign rs2_bypass = wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == CNT_ONE);
`else
    assign rs1_bypass = 1'b0;
    assign rs2_bypass = 1'b0;
`endif

    // x0 never reports busy, so no explicit rs==0 qualifier is needed.
    assign raw1 = issue_use_rs1 && busy[issue_rs1] && !rs1_bypass;
    assign raw2 = issue_use_rs2 && busy[issue_rs2] && !rs2_bypass;
    assign waw  = issue_is_write && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);

    assign issue_ready = !(raw1 || raw2 || waw) && !flush;

    // issue_ready already includes !flush; writeback is gated explicitly.
    assign issue_fire = issue_valid && issue_ready && issue_is_write && (issue_rd != '0);
    assign wb_fire    = wb_valid && !flush && (wb_rd != '0);

    for (genvar i = 0; i < NREG; i++) begin : g_entry
        if (i == 0) begin : g_x0
            assign inc_vec[i] = 1'b0;
            assign dec_vec[i] = 1'b0;
        end else begin : g_xn
            assign inc_vec[i] = issue_fire && (issue_rd == reg_idx_t'(i));
            assign dec_vec[i] = wb_fire && (wb_rd == reg_idx_t'(i));
        end

        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk       (clk),
            .reset     (reset),
            .clear     (flush),
            .inc       (inc_vec[i]),
            .dec       (dec_vec[i]),
            .cnt       (cnt[i]),
            .busy      (busy[i]),
            .underflow (uf_hit[i])
        );
    end

    assign busy_mask = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wb_underflow <= 1'b0;
        else if (flush)
            wb_underflow <= 1'b0;
        else if (|uf_hit)
            wb_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_use_rs1, issue_use_rs2, issue_is_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic        wb_underflow;

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_is_write(issue_is_write),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_mask(busy_mask), .wb_underflow(wb_underflow)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    localparam int MAXC = 3;
    int m_cnt [32];
    bit m_uf;

    function automatic bit m_src_busy(int r);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
        if (wb_valid && int'(wb_rd) == r && m_cnt[r] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        bit hz = 1'b0;
        if (issue_use_rs1 && m_src_busy(int'(issue_rs1))) hz = 1'b1;
        if (issue_use_rs2 && m_src_busy(int'(issue_rs2))) hz = 1'b1;
        if (issue_is_write && issue_rd != 0 && m_cnt[int'(issue_rd)] == MAXC) hz = 1'b1;
        return !hz && !flush;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        for (int i = 1; i < 32; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] <= 0;
            m_uf <= 1'b0;
        end else begin
            if (wb_valid && wb_rd != 0 && m_cnt[int'(wb_rd)] == 0) m_uf <= 1'b1;
            if (issue_valid && m_ready() && issue_is_write && issue_rd != 0 &&
                !(wb_valid && wb_rd == issue_rd))
                m_cnt[int'(issue_rd)] <= m_cnt[int'(issue_rd)] + 1;
            if (wb_valid && wb_rd != 0 && m_cnt[int'(wb_rd)] != 0 &&
                !(issue_valid && m_ready() && issue_is_write && issue_rd == wb_rd))
                m_cnt[int'(wb_rd)] <= m_cnt[int'(wb_rd)] - 1;
        end
    end

    // Single compare process: outputs against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'b0, issue_ready}, {31'b0, m_ready()});
            chk("busy_mask", busy_mask, m_mask());
            chk("wb_underflow", {31'b0, wb_underflow}, {31'b0, m_uf});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_use_rs1 = 0; issue_use_rs2 = 0; issue_is_write = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [4:0] rd);
        idle(); issue_valid = 1; issue_is_write = 1; issue_rd = rd;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        chk("reset busy_mask", busy_mask, 32'h0);
        chk("reset underflow", {31'b0, wb_underflow}, 32'h0);
        chk("reset ready", {31'b0, issue_ready}, 32'h1);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        // RAW on x5 until writeback
        cyc(); wr(5'd5); cyc();
        idle(); issue_valid = 1; issue_rs1 = 5; issue_use_rs1 = 1;
        #1 chk("raw ready", {31'b0, issue_ready}, 32'h0);
        chk("raw busy", busy_mask, 32'h20);
        cyc(); chk("raw ready hold", {31'b0, issue_ready}, 32'h0);
        wb_valid = 1; wb_rd = 5;
`ifdef SCOREBOARD_BYPASS_EN
        #1 chk("bypass ready", {31'b0, issue_ready}, 32'h1);
`else
        #1 chk("no-bypass ready", {31'b0, issue_ready}, 32'h0);
`endif
        cyc(); wb_valid = 0;
        #1 chk("after wb ready", {31'b0, issue_ready}, 32'h1);
        chk("after wb busy", busy_mask, 32'h0);
        cyc(); idle();

        // WAW saturation on x7
        wr(5'd7); cyc(); cyc(); cyc();
        #1 chk("sat ready", {31'b0, issue_ready}, 32'h0);
        chk("sat busy", busy_mask, 32'h80);
        wb_valid = 1; wb_rd = 7;
        #1 chk("sat ready w/ wb", {31'b0, issue_ready}, 32'h0);
        cyc(); wb_valid = 0;
        #1 chk("unsat ready", {31'b0, issue_ready}, 32'h1);
        idle(); wb_valid = 1; wb_rd = 7;
        cyc(); cyc(); idle();
        #1 chk("drained busy", busy_mask, 32'h0);

        // x0 is never tracked
        wr(5'd0); cyc(); idle();
        #1 chk("x0 busy", busy_mask, 32'h0);
        wb_valid = 1; wb_rd = 0; cyc(); idle();
        #1 chk("x0 wb no underflow", {31'b0, wb_underflow}, 32'h0);

        // sticky underflow
        wb_valid = 1; wb_rd = 9; cyc(); idle();
        #1 chk("underflow set", {31'b0, wb_underflow}, 32'h1);
        cyc(); cyc();
        chk("underflow sticky", {31'b0, wb_underflow}, 32'h1);

        // flush, then async reset mid-issue
        wr(5'd5); cyc(); wr(5'd7); cyc(); idle();
        #1 chk("pre-flush busy", busy_mask, 32'hA0);
        flush = 1; issue_valid = 1; issue_is_write = 1; issue_rd = 3;
        #1 chk("flush ready", {31'b0, issue_ready}, 32'h0);
        cyc(); idle();
        #1 chk("post-flush busy", busy_mask, 32'h0);
        chk("post-flush underflow", {31'b0, wb_underflow}, 32'h0);
        wb_valid = 1; wb_rd = 9; cyc(); wr(5'd5); cyc(); wr(5'd6);
        #1 chk("pre-reset busy", busy_mask, 32'h20);
        chk("pre-reset underflow", {31'b0, wb_underflow}, 32'h1);
        #1 reset = 1'b1;
        #1 chk("async reset busy", busy_mask, 32'h0);
        chk("async reset underflow", {31'b0, wb_underflow}, 32'h0);
        cyc(); idle(); reset = 1'b0;
        #1 chk("post-reset ready", {31'b0, issue_ready}, 32'h1);
        chk("post-reset busy", busy_mask, 32'h0);

        // randomized traffic over a small register window
        for (int n = 0; n < 3000; n++) begin
            cyc();
            issue_valid    = ($urandom_range(3) != 0);
            issue_rs1      = 5'($urandom_range(9));
            issue_rs2      = 5'($urandom_range(9));
            issue_rd       = 5'($urandom_range(9));
            issue_use_rs1  = $urandom_range(1);
            issue_use_rs2  = $urandom_range(1);
            issue_is_write = ($urandom_range(3) != 0);
            wb_valid       = ($urandom_range(9) < 4);
            wb_rd          = 5'($urandom_range(9));
            flush          = ($urandom_range(39) == 0);
            if (n == 1500) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        cyc(); idle();
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning the number of architectural integer registers tracked.
REQ-002 SHALL have parameter CNT_W, default 2, meaning the width of the per-register pending-write counter (max 2^CNT_W-1 outstanding writes).
REQ-003 SHALL have clock and reset as decided: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: issue_valid  input  1  decode presents an instruction.
REQ-007 SHALL have port: issue_ready  output  1  scoreboard accepts the instruction this cycle.
REQ-008 SHALL have ports: issue_rs1, issue_rs2, issue_rd  input  5 each  register indices.
REQ-009 SHALL have ports: issue_use_rs1, issue_use_rs2  input  1 each  operand actually read.
REQ-010 SHALL have port: issue_is_write  input  1  instruction writes rd (the decode is_write result).
REQ-011 SHALL have ports: wb_valid  input  1, wb_rd  input  5  writeback retires one write to wb_rd.
REQ-012 SHALL have port: flush  input  1  pipeline flush; discards all pending writes.
REQ-013 SHALL have port: busy_mask  output  NREG  bit i = register i has a pending write.
REQ-014 SHALL have port: wb_underflow  output  1  sticky error: writeback to a register with zero pending writes.

Function
REQ-015 SHALL keep one CNT_W-bit counter per register; register x0 is never tracked, its counter is constant 0.
REQ-016 SHALL raise a RAW hazard when use_rsN is 1 and the counter of rsN is nonzero (after bypass, REQ-025).
REQ-017 SHALL raise a WAW-saturation hazard when issue_is_write is 1, rd != 0, and the counter of rd equals 2^CNT_W-1.
REQ-018 SHALL drive issue_ready = !hazard && !flush, combinationally, independent of issue_valid.
REQ-019 SHALL increment the counter of rd on the clock edge where issue_valid && issue_ready && issue_is_write && rd != 0.
REQ-020 SHALL decrement the counter of wb_rd on the edge where wb_valid, wb_rd != 0 and the counter is nonzero.
REQ-021 SHALL, when wb_valid targets a register whose counter is 0, leave the counter at 0 and set wb_underflow.
REQ-022 SHALL leave a counter unchanged when an increment and a decrement hit the same register in the same cycle.
REQ-023 SHALL, on flush, clear all counters and wb_underflow on the next edge; issue and writeback in that cycle are ignored.
REQ-024 SHALL drive busy_mask[i] = (counter i != 0) from registered state; bit 0 is always 0.

Reset
REQ-026 SHALL, while reset is high, asynchronously force all counters to 0, busy_mask to 0, wb_underflow to 0.
REQ-027 SHALL drive issue_ready = 1 after reset with flush low, since no hazards exist.
REQ-028 SHALL discard any in-flight issue or writeback when reset is asserted mid-cycle.

Configuration
REQ-025 SHALL, with SCOREBOARD_BYPASS_EN defined, treat a source as not busy when wb_valid && wb_rd == rsN && counter == 1 in the same cycle. Without the macro, hazards use registered counters only, giving one extra stall cycle.

Structure
REQ-029 SHALL take reg_idx_t (5-bit), NREG and SB_CNT_W from the shared common package.
REQ-030 SHALL instantiate one sub-module sb_entry per register, holding the counter with inc/dec/clear inputs and busy/underflow outputs.

Verification
REQ-031 SHALL cover: issue ADD rd=5, is_write=1, then ADD rs1=5 next cycle -> issue_ready=0 until wb_rd=5; busy_mask[5]=1 meanwhile.
REQ-032 SHALL cover: same-cycle wb_rd=5 with a pending issue reading rs1=5, counter=1 -> issue_ready=1 with the macro, 0 without it.
REQ-033 SHALL cover: three writes to rd=7 with CNT_W=2 -> a fourth write to rd=7 gets issue_ready=0; one wb_rd=7 -> issue_ready=1.
REQ-034 SHALL cover: issue with rd=0 and is_write=1 -> busy_mask stays 0; wb_rd=0 -> no underflow.
REQ-035 SHALL cover: wb_valid to rd=9 with counter 0 -> wb_underflow=1 and stays 1 until flush or reset.
REQ-036 SHALL cover: busy_mask=0x0000_00A0 then flush=1 -> busy_mask=0 next cycle; reset pulsed mid-issue -> all outputs 0 asynchronously.
